// File: rtl/uart_bridge_pkg.sv
// Shared encodings for the UART GPIO bridge: FSM states, command byte fields, reply constants.
// Purely declarative; no latency or flow-control behaviour of its own.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        SEND      = 2'd2,
        WAIT_TX   = 2'd3
    } state_t;

    localparam int W_BIT   = 7;
    localparam int RSV_MSB = 6;
    localparam int RSV_LSB = 4;
    localparam int IDX_MSB = 3;
    localparam int IDX_LSB = 0;

    localparam logic [7:0] ERR_BYTE = 8'hEE;

    function automatic logic cmd_valid(input logic [7:0] cmd, input int num_ports);
        return (cmd[RSV_MSB:RSV_LSB] == 3'b000) && (int'(cmd[IDX_MSB:IDX_LSB]) < num_ports);
    endfunction

endpackage

// File: rtl/async_receiver.sv
// UART 8N1 receiver: RxD_data_ready pulses one cycle at mid stop bit, RxD_data holds until the next byte.
// No backpressure: a byte not taken on its strobe is lost by the consumer.
module async_receiver #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       RxD,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);

    logic [1:0]    r_sync     = 2'b11;
    logic          r_active   = 1'b0;
    logic [3:0]    r_bit_cnt  = 4'd0;
    logic [CW-1:0] r_baud_cnt = '0;
    logic [7:0]    r_data     = 8'h00;
    logic          r_ready    = 1'b0;
    logic          w_rx;

    assign w_rx = r_sync[1];

    // Bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit; samples land mid-bit.
    always_ff @(posedge clk) begin
        r_sync  <= {r_sync[0], RxD};
        r_ready <= 1'b0;
        if (!r_active) begin
            if (!w_rx) begin
                r_active   <= 1'b1;
                r_bit_cnt  <= 4'd0;
                r_baud_cnt <= CW'(DIV / 2);
            end
        end else if (r_baud_cnt == CW'(DIV - 1)) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 4'd0) begin
                if (w_rx) r_active <= 1'b0;
                else      r_bit_cnt <= 4'd1;
            end else if (r_bit_cnt == 4'd9) begin
                r_active <= 1'b0;
                r_ready  <= w_rx;
            end else begin
                r_data    <= {w_rx, r_data[7:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
        end
    end

    assign RxD_data_ready = r_ready;
    assign RxD_data       = r_data;
endmodule

// File: rtl/async_transmitter.sv
// UART 8N1 transmitter; TxD_busy rises the cycle after an accepted TxD_start and spans start..stop plus one idle bit.
// TxD_start while busy is ignored, so callers must wait for TxD_busy low.
module async_transmitter #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       TxD_busy
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);

    logic          r_active   = 1'b0;
    logic [3:0]    r_bit_cnt  = 4'd0;
    logic [CW-1:0] r_baud_cnt = '0;
    logic [9:0]    r_shift    = 10'h3FF;

    // The trailing idle bit period gives the receiving side slack between frames.
    always_ff @(posedge clk) begin
        if (!r_active) begin
            if (TxD_start) begin
                r_active   <= 1'b1;
                r_shift    <= {1'b1, TxD_data, 1'b0};
                r_bit_cnt  <= 4'd0;
                r_baud_cnt <= '0;
            end
        end else if (r_baud_cnt == CW'(DIV - 1)) begin
            r_baud_cnt <= '0;
            r_shift    <= {1'b1, r_shift[9:1]};
            if (r_bit_cnt == 4'd10) r_active  <= 1'b0;
            else                    r_bit_cnt <= r_bit_cnt + 4'd1;
        end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
        end
    end

    assign TxD      = r_active ? r_shift[0] : 1'b1;
    assign TxD_busy = r_active;
endmodule

// File: rtl/uart_bridge_fsm.sv
// Command FSM and GPout registers; GPout updates 1 clk after the data strobe, a byte received while replying is dropped.
// Optional WAIT_DATA timeout under UART_BRIDGE_TIMEOUT_EN; replies wait for the transmitter to go idle.
module uart_bridge_fsm
    import uart_bridge_pkg::*;
#(
    parameter int         NUM_PORTS = 4,
    parameter logic [7:0] GP_RESET  = 8'h00
`ifdef UART_BRIDGE_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 2500000
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rx_vld,
    input  logic [7:0]             i_rx_dat,
    input  logic                   i_tx_busy,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_dat,
    input  logic [8*NUM_PORTS-1:0] i_gp_in,
    output logic [8*NUM_PORTS-1:0] o_gp_out,
    output logic                   o_cmd_err,
    output logic                   o_rx_overrun
);
    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_idx;
    logic [7:0]             r_reply;
    logic                   r_tx_start, r_cmd_err, r_rx_overrun;
    logic [8*NUM_PORTS-1:0] r_gp_out;

    logic       w_cmd_err, w_overrun, w_reply_ld, w_gp_wr, w_idx_ld, w_tx_start;
    logic [7:0] w_reply_nxt, w_gp_sel;

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst || r_state != WAIT_DATA) r_to_cnt <= '0;
        else                             r_to_cnt <= r_to_cnt + 32'd1;
    end
`endif

    always_comb begin
        w_gp_sel = 8'h00;
        for (int p = 0; p < NUM_PORTS; p++)
            if (i_rx_dat[IDX_MSB:IDX_LSB] == p[3:0]) w_gp_sel = i_gp_in[p*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_err   = 1'b0;
        w_overrun   = 1'b0;
        w_reply_ld  = 1'b0;
        w_reply_nxt = r_reply;
        w_gp_wr     = 1'b0;
        w_idx_ld    = 1'b0;
        w_tx_start  = 1'b0;
        case (r_state)
            IDLE: if (i_rx_vld) begin
                if (!cmd_valid(i_rx_dat, NUM_PORTS)) begin
                    w_reply_nxt = ERR_BYTE;
                    w_reply_ld  = 1'b1;
                    w_cmd_err   = 1'b1;
                    w_state_nxt = SEND;
                end else if (i_rx_dat[W_BIT]) begin
                    w_idx_ld    = 1'b1;
                    w_state_nxt = WAIT_DATA;
                end else begin
                    w_reply_nxt = w_gp_sel;
                    w_reply_ld  = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            WAIT_DATA: if (i_rx_vld) begin
                w_gp_wr     = 1'b1;
                w_reply_nxt = i_rx_dat;
                w_reply_ld  = 1'b1;
                w_state_nxt = SEND;
            end
`ifdef UART_BRIDGE_TIMEOUT_EN
            else if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                w_cmd_err   = 1'b1;
                w_state_nxt = IDLE;
            end
`endif
            SEND: begin
                w_overrun = i_rx_vld;
                if (!i_tx_busy) begin
                    w_tx_start  = 1'b1;
                    w_state_nxt = WAIT_TX;
                end
            end
            // Busy only rises the cycle after the registered start reaches the transmitter.
            WAIT_TX: begin
                w_overrun = i_rx_vld;
                if (!r_tx_start && !i_tx_busy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gp_out     <= {NUM_PORTS{GP_RESET}};
            r_idx        <= 4'd0;
            r_reply      <= 8'h00;
            r_tx_start   <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_tx_start   <= w_tx_start;
            r_cmd_err    <= w_cmd_err;
            r_rx_overrun <= w_overrun;
            if (w_idx_ld)   r_idx   <= i_rx_dat[IDX_MSB:IDX_LSB];
            if (w_reply_ld) r_reply <= w_reply_nxt;
            for (int p = 0; p < NUM_PORTS; p++)
                if (w_gp_wr && r_idx == p[3:0]) r_gp_out[p*8 +: 8] <= i_rx_dat;
        end
    end

    assign o_tx_start   = r_tx_start;
    assign o_tx_dat     = r_reply;
    assign o_gp_out     = r_gp_out;
    assign o_cmd_err    = r_cmd_err;
    assign o_rx_overrun = r_rx_overrun;
endmodule

// File: rtl/uart_gpio_bridge.sv
// Top level: UART link to NUM_PORTS GP byte ports; write reply 1 byte after the data byte, bytes arriving mid-reply are dropped.
// Defining UART_BRIDGE_TIMEOUT_EN abandons a write whose data byte does not arrive within TIMEOUT_CYCLES.
module uart_gpio_bridge
    import uart_bridge_pkg::*;
#(
    parameter int         NUM_PORTS      = 4,
    parameter int         CLK_FREQ       = 25000000,
    parameter int         BAUD           = 115200,
    parameter logic [7:0] GP_RESET       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 2500000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RxD,
    output logic                   TxD,
    output logic [8*NUM_PORTS-1:0] GPout,
    input  logic [8*NUM_PORTS-1:0] GPin,
    output logic                   cmd_err,
    output logic                   rx_overrun
);
    logic       w_rx_rdy, w_tx_start, w_tx_busy;
    logic [7:0] w_rx_dat, w_tx_dat;

    if (NUM_PORTS < 1 || NUM_PORTS > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("uart_gpio_bridge: NUM_PORTS must be 1..16 and TIMEOUT_CYCLES at least 2");
    end

    async_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .clk            (clk),
        .RxD            (RxD),
        .RxD_data_ready (w_rx_rdy),
        .RxD_data       (w_rx_dat)
    );

    async_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
        .clk       (clk),
        .TxD_start (w_tx_start),
        .TxD_data  (w_tx_dat),
        .TxD       (TxD),
        .TxD_busy  (w_tx_busy)
    );

    uart_bridge_fsm #(
        .NUM_PORTS (NUM_PORTS),
        .GP_RESET  (GP_RESET)
`ifdef UART_BRIDGE_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_rx_vld     (w_rx_rdy),
        .i_rx_dat     (w_rx_dat),
        .i_tx_busy    (w_tx_busy),
        .o_tx_start   (w_tx_start),
        .o_tx_dat     (w_tx_dat),
        .i_gp_in      (GPin),
        .o_gp_out     (GPout),
        .o_cmd_err    (cmd_err),
        .o_rx_overrun (rx_overrun)
    );
endmodule
